// File: rtl/ts_pkg.sv
// ---------------------------------------------------------------------------
// ts_pkg -- shared definitions for the timing-strobe generator (ts_gen).
//   state_e          : FSM state encoding (IDLE/HIGH/LOW, 2 bits)
//   HIGH_DEF_TICKS   : default high-phase length in ticks
//   LOW_DEF_TICKS    : default low-phase length in ticks
// ---------------------------------------------------------------------------
package ts_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_HIGH = 2'b01,
      S_LOW  = 2'b10
   } state_e;

   localparam int HIGH_DEF_TICKS = 5;
   localparam int LOW_DEF_TICKS  = 1;

endpackage : ts_pkg

// File: rtl/ts_prescaler.sv
// ---------------------------------------------------------------------------
// ts_prescaler -- divides clkin into a 1-cycle tick every PRESCALE cycles.
// Ports:
//   clkin    in  system clock, rising edge
//   reset_n  in  async active-low reset
//   clear    in  hold the count at 0 and suppress tick
//   tick     out 1 when count == PRESCALE-1 (and not cleared)
// ---------------------------------------------------------------------------
module ts_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clkin,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;

   always_comb begin
      if (clear || (cnt_q == LAST)) cnt_d = '0;
      else                          cnt_d = cnt_q + PW'(1);
   end

   assign tick = !clear && (cnt_q == LAST);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule : ts_prescaler

// File: rtl/ts_gen.sv
// ---------------------------------------------------------------------------
// ts_gen -- periodic timing strobe for the traffic FSM.
//   ts is high for active_high ticks, low for active_low ticks, repeating.
//   New lengths are captured into shadow registers on cfg_load and moved to
//   the active set only at a LOW->HIGH boundary (or at once while idle), so a
//   period in progress is never distorted.
// Optional feature: define TS_GEN_SENSOR_HOLD_EN to add the `sensor` input;
//   HIGH is then extended at its terminal tick until a tick sees sensor==1.
// Ports:
//   clkin, reset_n       clock / async active-low reset
//   en                   run enable; low forces IDLE
//   cfg_load             1-cycle strobe capturing cfg_high/cfg_low
//   cfg_high, cfg_low    requested phase lengths in ticks (0 is rejected)
//   sensor               (TS_GEN_SENSOR_HOLD_EN only) release for held HIGH
//   ts                   registered strobe (1 in IDLE and HIGH)
//   tick                 prescaler strobe
//   phase_cnt            ticks elapsed in the current phase
//   period_done          1-cycle pulse after each LOW->HIGH transition
//   cfg_err              sticky flag for a rejected cfg_load
// ---------------------------------------------------------------------------
module ts_gen
   import ts_pkg::*;
#(
   parameter int CW       = 8,
   parameter int PRESCALE = 1,
   parameter int HIGH_DEF = HIGH_DEF_TICKS,
   parameter int LOW_DEF  = LOW_DEF_TICKS
) (
   input  logic          clkin,
   input  logic          reset_n,
   input  logic          en,
   input  logic          cfg_load,
   input  logic [CW-1:0] cfg_high,
   input  logic [CW-1:0] cfg_low,
`ifdef TS_GEN_SENSOR_HOLD_EN
   input  logic          sensor,
`endif
   output logic          ts,
   output logic          tick,
   output logic [CW-1:0] phase_cnt,
   output logic          period_done,
   output logic          cfg_err
);

   state_e        state_q, state_d;
   logic [CW-1:0] phase_q, phase_d;
   logic          ts_q, ts_d;
   logic          pd_q, pd_d;
   logic          err_q, err_d;
   logic [CW-1:0] sh_high_q, sh_high_d, sh_low_q, sh_low_d;
   logic [CW-1:0] act_high_q, act_high_d, act_low_q, act_low_d;
   logic          load_ok;
   logic          hold_high;

   ts_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clkin   (clkin),
      .reset_n (reset_n),
      .clear   (state_q == S_IDLE),
      .tick    (tick)
   );

   assign load_ok = cfg_load && (cfg_high != '0) && (cfg_low != '0);

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      pd_d       = 1'b0;
      err_d      = err_q;
      sh_high_d  = sh_high_q;
      sh_low_d   = sh_low_q;
      act_high_d = act_high_q;
      act_low_d  = act_low_q;
      hold_high  = 1'b0;
`ifdef TS_GEN_SENSOR_HOLD_EN
      hold_high  = !sensor;
`endif

      if (cfg_load) begin
         if (load_ok) begin
            sh_high_d = cfg_high;
            sh_low_d  = cfg_low;
            err_d     = 1'b0;
         end else begin
            err_d     = 1'b1;
         end
      end

      // Idle has no period to protect: track the shadow (including a load
      // arriving this very cycle) so the first period uses it.
      if (state_q == S_IDLE) begin
         act_high_d = sh_high_d;
         act_low_d  = sh_low_d;
      end

      if (!en) begin
         state_d = S_IDLE;
         phase_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_HIGH;
               phase_d = '0;
            end
            S_HIGH: begin
               if (tick) begin
                  if (phase_q == act_high_q - CW'(1)) begin
                     // Held HIGH keeps phase_cnt frozen at its terminal value.
                     if (!hold_high) begin
                        state_d = S_LOW;
                        phase_d = '0;
                     end
                  end else begin
                     phase_d = phase_q + CW'(1);
                  end
               end
            end
            S_LOW: begin
               if (tick) begin
                  if (phase_q == act_low_q - CW'(1)) begin
                     state_d    = S_HIGH;
                     phase_d    = '0;
                     pd_d       = 1'b1;
                     // Uses shadow_d so a load on the boundary cycle applies
                     // to the period starting now.
                     act_high_d = sh_high_d;
                     act_low_d  = sh_low_d;
                  end else begin
                     phase_d = phase_q + CW'(1);
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               phase_d = '0;
            end
         endcase
      end

      ts_d = (state_d != S_LOW);
   end

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         ts_q       <= 1'b1;
         pd_q       <= 1'b0;
         err_q      <= 1'b0;
         sh_high_q  <= CW'(HIGH_DEF);
         sh_low_q   <= CW'(LOW_DEF);
         act_high_q <= CW'(HIGH_DEF);
         act_low_q  <= CW'(LOW_DEF);
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         ts_q       <= ts_d;
         pd_q       <= pd_d;
         err_q      <= err_d;
         sh_high_q  <= sh_high_d;
         sh_low_q   <= sh_low_d;
         act_high_q <= act_high_d;
         act_low_q  <= act_low_d;
      end
   end

   assign ts          = ts_q;
   assign phase_cnt   = phase_q;
   assign period_done = pd_q;
   assign cfg_err     = err_q;

endmodule : ts_gen

// File: tb/tb_ts_gen.sv
// ---------------------------------------------------------------------------
// tb_ts_gen -- directed self-checking bench for ts_gen.
//   u_dut  : default parameters (PRESCALE=1, 5/1)
//   u_dut4 : PRESCALE=4
// Inputs change 1 time unit after the rising edge; outputs are read there
// too, so "cycle i" below means the clock period following edge i.
// ---------------------------------------------------------------------------
module tb_ts_gen;

   logic       clkin = 1'b0;
   logic       reset_n = 1'b0;
   logic       en = 1'b0;
   logic       en4 = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_high = 8'd0;
   logic [7:0] cfg_low = 8'd0;
   logic       sensor = 1'b1;

   logic       ts, tick, period_done, cfg_err;
   logic [7:0] phase_cnt;
   logic       ts4, tick4, pd4, err4;
   logic [7:0] phase4;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clkin = ~clkin;

   ts_gen u_dut (
      .clkin       (clkin),
      .reset_n     (reset_n),
      .en          (en),
      .cfg_load    (cfg_load),
      .cfg_high    (cfg_high),
      .cfg_low     (cfg_low),
`ifdef TS_GEN_SENSOR_HOLD_EN
      .sensor      (sensor),
`endif
      .ts          (ts),
      .tick        (tick),
      .phase_cnt   (phase_cnt),
      .period_done (period_done),
      .cfg_err     (cfg_err)
   );

   ts_gen #(.PRESCALE(4)) u_dut4 (
      .clkin       (clkin),
      .reset_n     (reset_n),
      .en          (en4),
      .cfg_load    (1'b0),
      .cfg_high    (8'd0),
      .cfg_low     (8'd0),
`ifdef TS_GEN_SENSOR_HOLD_EN
      .sensor      (1'b1),
`endif
      .ts          (ts4),
      .tick        (tick4),
      .phase_cnt   (phase4),
      .period_done (pd4),
      .cfg_err     (err4)
   );

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   task automatic do_reset();
      en       = 1'b0;
      en4      = 1'b0;
      cfg_load = 1'b0;
      sensor   = 1'b1;
      reset_n  = 1'b0;
      step();
      step();
      reset_n  = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++; if (ts !== 1'b1) $display("FAIL reset_ts got=%b exp=1", ts); else pass_cnt++;
      total_cnt++; if (tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", tick); else pass_cnt++;
      total_cnt++; if (phase_cnt !== 8'd0) $display("FAIL reset_phase got=%0d exp=0", phase_cnt); else pass_cnt++;
      total_cnt++; if (period_done !== 1'b0) $display("FAIL reset_pd got=%b exp=0", period_done); else pass_cnt++;
      total_cnt++; if (cfg_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", cfg_err); else pass_cnt++;
      step();  // en low: must stay idle
      total_cnt++; if (tick !== 1'b0) $display("FAIL idle_tick got=%b exp=0", tick); else pass_cnt++;
   endtask

   // Default 5/1 waveform, PRESCALE=1.
   task automatic test_defaults();
      logic exp_ts, exp_pd;
      logic [7:0] exp_ph;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 18; i++) begin
         step();
         exp_ts = (i % 6) != 5;
         exp_pd = (i > 0) && ((i % 6) == 0);
         exp_ph = ((i % 6) == 5) ? 8'd0 : 8'(i % 6);
         total_cnt++; if (ts !== exp_ts) $display("FAIL def_ts cyc=%0d got=%b exp=%b", i, ts, exp_ts); else pass_cnt++;
         total_cnt++; if (period_done !== exp_pd) $display("FAIL def_pd cyc=%0d got=%b exp=%b", i, period_done, exp_pd); else pass_cnt++;
         total_cnt++; if (phase_cnt !== exp_ph) $display("FAIL def_phase cyc=%0d got=%0d exp=%0d", i, phase_cnt, exp_ph); else pass_cnt++;
         total_cnt++; if (tick !== 1'b1) $display("FAIL def_tick cyc=%0d got=%b exp=1", i, tick); else pass_cnt++;
      end
   endtask

   // PRESCALE=4: high 20 cycles, low 4, tick every 4th cycle.
   task automatic test_prescale();
      logic exp_ts, exp_tick, exp_pd;
      logic [7:0] exp_ph;
      do_reset();
      en4 = 1'b1;
      for (int i = 0; i < 48; i++) begin
         step();
         exp_ts   = (i % 24) < 20;
         exp_tick = (i % 4) == 3;
         exp_pd   = (i > 0) && ((i % 24) == 0);
         exp_ph   = exp_ts ? 8'((i % 24) / 4) : 8'd0;
         total_cnt++; if (ts4 !== exp_ts) $display("FAIL ps_ts cyc=%0d got=%b exp=%b", i, ts4, exp_ts); else pass_cnt++;
         total_cnt++; if (tick4 !== exp_tick) $display("FAIL ps_tick cyc=%0d got=%b exp=%b", i, tick4, exp_tick); else pass_cnt++;
         total_cnt++; if (pd4 !== exp_pd) $display("FAIL ps_pd cyc=%0d got=%b exp=%b", i, pd4, exp_pd); else pass_cnt++;
         total_cnt++; if (phase4 !== exp_ph) $display("FAIL ps_phase cyc=%0d got=%0d exp=%0d", i, phase4, exp_ph); else pass_cnt++;
      end
      en4 = 1'b0;
   endtask

   // cfg_load(3,3) in cycle 2: period 0 stays 5/1, next period is 3/3.
   task automatic test_cfg_midhigh();
      logic exp_ts, exp_pd;
      do_reset();
      en = 1'b1;
      step(); step(); step();  // cycle 2
      cfg_load = 1'b1; cfg_high = 8'd3; cfg_low = 8'd3;
      step();                  // cycle 3
      cfg_load = 1'b0;
      total_cnt++; if (cfg_err !== 1'b0) $display("FAIL cfg33_err got=%b exp=0", cfg_err); else pass_cnt++;
      for (int i = 3; i <= 14; i++) begin
         if (i > 3) step();
         exp_ts = (i < 5) || (i >= 6 && i <= 8) || (i >= 12);
         exp_pd = (i == 6) || (i == 12);
         total_cnt++; if (ts !== exp_ts) $display("FAIL cfg33_ts cyc=%0d got=%b exp=%b", i, ts, exp_ts); else pass_cnt++;
         total_cnt++; if (period_done !== exp_pd) $display("FAIL cfg33_pd cyc=%0d got=%b exp=%b", i, period_done, exp_pd); else pass_cnt++;
      end
   endtask

   // Rejected cfg_load(0,2), then accepted cfg_load(2,2).
   task automatic test_cfg_err();
      logic exp_ts;
      do_reset();
      en = 1'b1;
      step();                  // cycle 0
      cfg_load = 1'b1; cfg_high = 8'd0; cfg_low = 8'd2;
      step();                  // cycle 1
      cfg_load = 1'b0;
      total_cnt++; if (cfg_err !== 1'b1) $display("FAIL err_set got=%b exp=1", cfg_err); else pass_cnt++;
      for (int i = 1; i <= 13; i++) begin
         if (i > 1) step();
         exp_ts = (i % 6) != 5;
         total_cnt++; if (ts !== exp_ts) $display("FAIL err_ts cyc=%0d got=%b exp=%b", i, ts, exp_ts); else pass_cnt++;
      end
      total_cnt++; if (cfg_err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", cfg_err); else pass_cnt++;
      cfg_load = 1'b1; cfg_high = 8'd2; cfg_low = 8'd2;
      step();                  // cycle 14
      cfg_load = 1'b0;
      total_cnt++; if (cfg_err !== 1'b0) $display("FAIL err_clear got=%b exp=0", cfg_err); else pass_cnt++;
      for (int i = 14; i <= 22; i++) begin
         if (i > 14) step();
         exp_ts = (i <= 16) || (i == 18) || (i == 19) || (i == 22);
         total_cnt++; if (ts !== exp_ts) $display("FAIL err22_ts cyc=%0d got=%b exp=%b", i, ts, exp_ts); else pass_cnt++;
      end
   endtask

   // en dropped in LOW: back to idle with no period_done, then restart.
   task automatic test_en_drop();
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 6; i++) step();  // cycle 5 (LOW)
      total_cnt++; if (ts !== 1'b0) $display("FAIL endrop_low got=%b exp=0", ts); else pass_cnt++;
      en = 1'b0;
      step();
      total_cnt++; if (ts !== 1'b1) $display("FAIL endrop_ts got=%b exp=1", ts); else pass_cnt++;
      total_cnt++; if (phase_cnt !== 8'd0) $display("FAIL endrop_phase got=%0d exp=0", phase_cnt); else pass_cnt++;
      total_cnt++; if (period_done !== 1'b0) $display("FAIL endrop_pd got=%b exp=0", period_done); else pass_cnt++;
      total_cnt++; if (tick !== 1'b0) $display("FAIL endrop_tick got=%b exp=0", tick); else pass_cnt++;
      step();
      total_cnt++; if (ts !== 1'b1) $display("FAIL endrop_hold got=%b exp=1", ts); else pass_cnt++;
      en = 1'b1;
      step();                  // restart cycle 0
      total_cnt++; if (ts !== 1'b1 || phase_cnt !== 8'd0) $display("FAIL restart0 got=%b/%0d exp=1/0", ts, phase_cnt); else pass_cnt++;
      for (int i = 0; i < 4; i++) step();  // cycle 4
      total_cnt++; if (ts !== 1'b1 || phase_cnt !== 8'd4) $display("FAIL restart4 got=%b/%0d exp=1/4", ts, phase_cnt); else pass_cnt++;
      step();                  // cycle 5
      total_cnt++; if (ts !== 1'b0) $display("FAIL restart5 got=%b exp=0", ts); else pass_cnt++;
   endtask

   // Asynchronous reset in the middle of HIGH, with cfg_err previously set.
   task automatic test_async_reset();
      do_reset();
      en = 1'b1;
      step();                  // cycle 0
      cfg_load = 1'b1; cfg_high = 8'd0; cfg_low = 8'd0;
      step();                  // cycle 1
      cfg_load = 1'b0;
      step(); step();          // cycle 3, phase 3
      total_cnt++; if (phase_cnt !== 8'd3 || cfg_err !== 1'b1) $display("FAIL arst_pre got=%0d/%b exp=3/1", phase_cnt, cfg_err); else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;                      // well before the next rising edge
      total_cnt++; if (ts !== 1'b1) $display("FAIL arst_ts got=%b exp=1", ts); else pass_cnt++;
      total_cnt++; if (tick !== 1'b0) $display("FAIL arst_tick got=%b exp=0", tick); else pass_cnt++;
      total_cnt++; if (phase_cnt !== 8'd0) $display("FAIL arst_phase got=%0d exp=0", phase_cnt); else pass_cnt++;
      total_cnt++; if (period_done !== 1'b0) $display("FAIL arst_pd got=%b exp=0", period_done); else pass_cnt++;
      total_cnt++; if (cfg_err !== 1'b0) $display("FAIL arst_err got=%b exp=0", cfg_err); else pass_cnt++;
      step();
      reset_n = 1'b1;
      en = 1'b0;
   endtask

`ifdef TS_GEN_SENSOR_HOLD_EN
   // sensor low for cycles 3..12: HIGH held through cycle 13 (14 cycles).
   task automatic test_sensor_hold();
      logic exp_ts;
      logic [7:0] exp_ph;
      do_reset();
      en = 1'b1;
      for (int i = 0; i <= 15; i++) begin
         step();
         sensor = !(i >= 3 && i <= 12);
         exp_ts = (i != 14);
         exp_ph = (i <= 13) ? 8'((i < 4) ? i : 4) : 8'd0;
         total_cnt++; if (ts !== exp_ts) $display("FAIL sens_ts cyc=%0d got=%b exp=%b", i, ts, exp_ts); else pass_cnt++;
         total_cnt++; if (phase_cnt !== exp_ph) $display("FAIL sens_phase cyc=%0d got=%0d exp=%0d", i, phase_cnt, exp_ph); else pass_cnt++;
      end
      sensor = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_defaults();
      test_prescale();
      test_cfg_midhigh();
      test_cfg_err();
      test_en_drop();
      test_async_reset();
`ifdef TS_GEN_SENSOR_HOLD_EN
      test_sensor_hold();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_ts_gen
